// File: rtl/instruction_fetch_sequencer_pkg.sv
// Shared encodings for the fetch/sequencing stage and control_unit decode.
`timescale 1ns/1ps
package instruction_fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    PH_FETCH  = 2'b00,
    PH_DECODE = 2'b01,
    PH_EXEC   = 2'b10,
    PH_WB     = 2'b11
  } phase_t;

  localparam int INSTR_WIDTH = 8;
  localparam int OPC_MSB     = 7;
  localparam int OPC_LSB     = 6;

  localparam logic [1:0] OPC_BRANCH = 2'b11;

  function automatic logic [1:0] opcode_of(input logic [INSTR_WIDTH-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/instruction_fetch_sequencer_pc_next_calc.sv
// Next-PC selection: sequential increment with PC_LAST wrap, or branch-relative.
`timescale 1ns/1ps
module pc_next_calc
  import instruction_fetch_sequencer_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] PC_LAST    = ADDR_WIDTH'(255),
  parameter int                    IMM_WIDTH  = 2
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [IMM_WIDTH-1:0]  offset,
  input  logic                  branch_q,
  output logic [ADDR_WIDTH-1:0] next_pc
);

  logic [ADDR_WIDTH-1:0] offset_ext;

  always_comb begin
    offset_ext = {{(ADDR_WIDTH-IMM_WIDTH){offset[IMM_WIDTH-1]}}, offset};
    // Branch targets wrap modulo 2^ADDR_WIDTH and ignore PC_LAST.
    if (branch_q) begin
      next_pc = pc + ADDR_WIDTH'(1) + offset_ext;
    end else if (pc == PC_LAST) begin
      next_pc = '0;
    end else begin
      next_pc = pc + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// Four-phase fetch sequencer: latches the ROM byte, resolves branches, commits and updates the PC.
`timescale 1ns/1ps
module instruction_fetch_sequencer
  import instruction_fetch_sequencer_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] PC_LAST    = ADDR_WIDTH'(255),
  parameter int                    IMM_WIDTH  = 2
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  step_en,
  input  logic [7:0]            instruction_in,
  input  logic                  branch_taken,
  output logic [ADDR_WIDTH-1:0] read_address,
  output logic [7:0]            instruction_out,
  output logic [1:0]            phase,
  output logic                  instr_valid,
  output logic                  commit
);

  phase_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc, pc_next;
  logic [7:0]            ir;
  logic                  valid_q, branch_q, commit_q;
  logic                  load_ir, exec_en, wb_en;

  always_ff @(posedge clock) begin
    if (clear) state <= PH_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (step_en) begin
      case (state)
        PH_FETCH:  state_nxt = PH_DECODE;
        PH_DECODE: state_nxt = PH_EXEC;
        PH_EXEC:   state_nxt = PH_WB;
        PH_WB:     state_nxt = PH_FETCH;
        default:   state_nxt = PH_FETCH;
      endcase
    end
  end

  always_comb begin
    phase   = state;
    load_ir = step_en && (state == PH_FETCH);
    exec_en = step_en && (state == PH_EXEC);
    wb_en   = step_en && (state == PH_WB);
  end

  pc_next_calc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .PC_LAST    (PC_LAST),
    .IMM_WIDTH  (IMM_WIDTH)
  ) u_pc_next (
    .pc       (pc),
    .offset   (ir[IMM_WIDTH-1:0]),
    .branch_q (branch_q),
    .next_pc  (pc_next)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      pc       <= '0;
      ir       <= 8'h00;
      valid_q  <= 1'b0;
      branch_q <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      commit_q <= wb_en;
      if (load_ir) begin
        ir      <= instruction_in;
        valid_q <= 1'b1;
      end
      // Only a branch opcode may act on the resolved condition.
      if (exec_en) branch_q <= branch_taken && (opcode_of(ir) == OPC_BRANCH);
      if (wb_en)   pc       <= pc_next;
    end
  end

  assign read_address    = pc;
  assign instruction_out = ir;
  assign instr_valid     = valid_q;
  assign commit          = commit_q;

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Directed-vector bench with a commit-driven scoreboard; the DUT runs with PC_LAST=3.
`timescale 1ns/1ps
module tb_instruction_fetch_sequencer;

  localparam int MODE_NONE    = 0;
  localparam int MODE_EXEC    = 1;
  localparam int MODE_OUTSIDE = 2;

  logic       clock;
  logic       clear;
  logic       step_en;
  logic [7:0] instruction_in;
  logic       branch_taken;
  logic [7:0] read_address;
  logic [7:0] instruction_out;
  logic [1:0] phase;
  logic       instr_valid;
  logic       commit;

  logic [7:0]  rom [256];
  logic [15:0] exp_q [$];
  logic [7:0]  cur_pc;
  int          n_vec;
  int          n_bad;

  instruction_fetch_sequencer #(
    .ADDR_WIDTH (8),
    .PC_LAST    (8'd3),
    .IMM_WIDTH  (2)
  ) dut (
    .clock           (clock),
    .clear           (clear),
    .step_en         (step_en),
    .instruction_in  (instruction_in),
    .branch_taken    (branch_taken),
    .read_address    (read_address),
    .instruction_out (instruction_out),
    .phase           (phase),
    .instr_valid     (instr_valid),
    .commit          (commit)
  );

  // clock / ROM
  initial clock = 1'b0;
  always #5 clock = ~clock;
  assign instruction_in = rom[read_address];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every commit pulse must match the oldest expected {ir, next pc}
  always @(negedge clock) begin
    if (commit === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_commit", {instruction_out, read_address}, 16'hxxxx);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("commit_ir", {8'h00, instruction_out}, {8'h00, e[15:8]});
        check("commit_pc", {8'h00, read_address}, {8'h00, e[7:0]});
      end
    end
  end

  // driver tasks
  task automatic step(input logic bt);
    @(negedge clock);
    step_en      = 1'b1;
    branch_taken = bt;
    @(negedge clock);
    step_en      = 1'b0;
    branch_taken = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clock);
  endtask

  task automatic do_instr(input logic [7:0] instr, input int mode, input logic [7:0] nxt);
    rom[cur_pc] = instr;
    exp_q.push_back({instr, nxt});
    step(mode == MODE_OUTSIDE);
    check("fetch_ir", {8'h00, instruction_out}, {8'h00, instr});
    check("fetch_phase", {14'h0, phase}, 16'h0001);
    check("fetch_valid", {15'h0, instr_valid}, 16'h0001);
    step(mode == MODE_OUTSIDE);
    check("decode_phase", {14'h0, phase}, 16'h0002);
    step(mode == MODE_EXEC);
    check("exec_phase", {14'h0, phase}, 16'h0003);
    check("exec_pc_hold", {8'h00, read_address}, {8'h00, cur_pc});
    step(mode == MODE_OUTSIDE);
    check("wb_phase", {14'h0, phase}, 16'h0000);
    cur_pc = nxt;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"},    {8'h00, read_address},    16'h0000);
    check({tag, "_phase"}, {14'h0, phase},           16'h0000);
    check({tag, "_valid"}, {15'h0, instr_valid},     16'h0000);
    check({tag, "_ir"},    {8'h00, instruction_out}, 16'h0000);
    check({tag, "_commit"}, {15'h0, commit},         16'h0000);
  endtask

  initial begin
    n_vec        = 0;
    n_bad        = 0;
    cur_pc       = 8'h00;
    clear        = 1'b1;
    step_en      = 1'b0;
    branch_taken = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;

    // reset with step_en toggling, then release and hold
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      step_en = i[0];
    end
    @(negedge clock);
    clear   = 1'b0;
    step_en = 1'b0;
    @(negedge clock);
    check_reset_state("reset");
    repeat (10) @(negedge clock);
    check_reset_state("hold");

    // sequential fetch, opcode gating, PC_LAST wrap
    do_instr(8'h1B, MODE_NONE,    8'h01);
    do_instr(8'h46, MODE_EXEC,    8'h02);  // opcode 01 ignores branch_taken
    do_instr(8'hC1, MODE_OUTSIDE, 8'h03);  // taken only outside EXECUTE
    do_instr(8'h80, MODE_NONE,    8'h00);  // PC_LAST=3 wraps to 0
    do_instr(8'hC2, MODE_EXEC,    8'hFF);  // 0+1-2
    do_instr(8'hFF, MODE_EXEC,    8'hFF);  // halt idiom: self-loop
    do_instr(8'hFF, MODE_EXEC,    8'hFF);
    do_instr(8'hFF, MODE_EXEC,    8'hFF);
    do_instr(8'hC3, MODE_NONE,    8'h00);  // not taken: 255 -> 0
    do_instr(8'hC1, MODE_EXEC,    8'h02);
    do_instr(8'hC1, MODE_EXEC,    8'h04);
    do_instr(8'h00, MODE_NONE,    8'h05);
    do_instr(8'hC1, MODE_EXEC,    8'h07);  // PC=5, +1 -> 7
    do_instr(8'hC2, MODE_EXEC,    8'h06);
    do_instr(8'hC2, MODE_EXEC,    8'h05);
    do_instr(8'hC2, MODE_EXEC,    8'h04);  // PC=5, -2 -> 4
    do_instr(8'hC1, MODE_EXEC,    8'h06);
    do_instr(8'hC1, MODE_EXEC,    8'h08);
    do_instr(8'h00, MODE_NONE,    8'h09);

    // clear during EXECUTE of a taken branch at PC=9
    rom[cur_pc] = 8'hC1;
    step(1'b0);
    step(1'b0);
    check("pre_clear_phase", {14'h0, phase}, 16'h0002);
    @(negedge clock);
    clear        = 1'b1;
    step_en      = 1'b1;
    branch_taken = 1'b1;
    @(negedge clock);
    clear        = 1'b0;
    step_en      = 1'b0;
    branch_taken = 1'b0;
    check_reset_state("midop");
    repeat (8) @(negedge clock);
    cur_pc = 8'h00;
    do_instr(8'h1B, MODE_NONE, 8'h01);

    repeat (5) @(negedge clock);
    check("scoreboard_drain", 16'(exp_q.size()), 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
